// File: rtl/pn_i2s_pkg.sv
// Shared definitions for the PN audio I2S frame scheduler: mode codes,
// scheduler state codes and the saturating per-channel adder.
package pn_i2s_pkg;

    typedef enum logic [1:0] {
        MODE_S0  = 2'd0,
        MODE_S1  = 2'd1,
        MODE_PRI = 2'd2,
        MODE_MIX = 2'd3
    } mode_e;

    localparam logic [1:0] ST_WAIT_LOW = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_FETCH    = 2'd2;

    // Signed 16-bit add clamped to [-32768, 32767].
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (s[16] != s[15]) begin
            return s[16] ? 16'h8000 : 16'h7FFF;
        end
        return s[15:0];
    endfunction

endpackage

// File: rtl/pn_i2s_hold.sv
// One-deep holding register for a sample source.
// Handshake: a word transfers on any edge where valid && ready; ready is ~full
// and never depends on valid. take frees the register on the same edge.
module pn_i2s_hold (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic        valid,
    output logic        ready,
    input  logic        take,
    output logic [31:0] q,
    output logic        full
);

    assign ready = ~full;

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            q    <= 32'd0;
        end else if (valid && !full) begin
            full <= 1'b1;
            q    <= data;
        end else if (take) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/pn_i2s_sched.sv
// Frame scheduler for the I2S transmitter: picks or mixes two buffered sources
// and updates the output word once per LR frame, at the start of the left half.
module pn_i2s_sched
    import pn_i2s_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             ax_clk,
    input  logic             ax_rst,
    input  logic [31:0]      s0_data,
    input  logic             s0_valid,
    output logic             s0_ready,
    input  logic [31:0]      s1_data,
    input  logic             s1_valid,
    output logic             s1_ready,
    input  logic [1:0]       cfg_mode,
    input  logic             cfg_mute,
    input  logic             cfg_uz,
    input  logic             i2s_ready,
    input  logic             i2s_lrck,
    output logic [31:0]      i2s_data,
    output logic             i2s_valid,
    output logic [CNT_W-1:0] underrun_cnt,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [1:0]       fsm_state
);

    logic [SYNC_STAGES-1:0] rdy_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic                   rdy_s;
    logic                   lr_s;
    logic [1:0]             state;
    logic                   fetch;
    logic [31:0]            h0_q;
    logic [31:0]            h1_q;
    logic                   h0_full;
    logic                   h1_full;
    logic                   use0;
    logic                   use1;
    logic                   take0;
    logic                   take1;
    logic                   starved;
    logic [31:0]            next_word;

    pn_i2s_hold u_hold0 (
        .clk   (ax_clk),
        .rst   (ax_rst),
        .data  (s0_data),
        .valid (s0_valid),
        .ready (s0_ready),
        .take  (take0),
        .q     (h0_q),
        .full  (h0_full)
    );

    pn_i2s_hold u_hold1 (
        .clk   (ax_clk),
        .rst   (ax_rst),
        .data  (s1_data),
        .valid (s1_valid),
        .ready (s1_ready),
        .take  (take1),
        .q     (h1_q),
        .full  (h1_full)
    );

    always_ff @(posedge ax_clk) begin
        if (ax_rst) begin
            rdy_sync <= '0;
            lr_sync  <= '0;
        end else begin
            rdy_sync <= {rdy_sync[SYNC_STAGES-2:0], i2s_ready};
            lr_sync  <= {lr_sync[SYNC_STAGES-2:0], i2s_lrck};
        end
    end

    assign rdy_s     = rdy_sync[SYNC_STAGES-1];
    assign lr_s      = lr_sync[SYNC_STAGES-1];
    assign fetch     = (state == ST_FETCH);
    assign fsm_state = state;

    always_comb begin
        use0 = 1'b0;
        use1 = 1'b0;
        case (cfg_mode)
            MODE_S0:  use0 = h0_full;
            MODE_S1:  use1 = h1_full;
            MODE_PRI: begin
                use0 = h0_full;
                use1 = !h0_full && h1_full;
            end
            default: begin
                use0 = h0_full;
                use1 = h1_full;
            end
        endcase

        starved = !(use0 || use1);
        take0   = fetch && use0;
        take1   = fetch && use1;

        if (use0 && use1) begin
            next_word = {sat_add16(h0_q[31:16], h1_q[31:16]),
                         sat_add16(h0_q[15:0],  h1_q[15:0])};
        end else if (use0) begin
            next_word = h0_q;
        end else if (use1) begin
            next_word = h1_q;
        end else if (cfg_uz) begin
            next_word = 32'd0;
        end else begin
            next_word = i2s_data;
        end

        if (cfg_mute) begin
            next_word = 32'd0;
        end
    end

    // Fetching only when ready rises in the left half keeps the word constant
    // across both halves of the frame the transmitter is about to shift.
    always_ff @(posedge ax_clk) begin
        if (ax_rst) begin
            state        <= ST_WAIT_LOW;
            i2s_data     <= 32'd0;
            i2s_valid    <= 1'b0;
            underrun_cnt <= '0;
            frame_cnt    <= '0;
        end else begin
            i2s_valid <= 1'b0;
            case (state)
                ST_WAIT_LOW: begin
                    if (!rdy_s) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (rdy_s) begin
                        state <= lr_s ? ST_WAIT_LOW : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state     <= ST_WAIT_LOW;
                    i2s_data  <= next_word;
                    i2s_valid <= 1'b1;
                    if (frame_cnt != '1) begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                    end
                    if (starved && (underrun_cnt != '1)) begin
                        underrun_cnt <= underrun_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_WAIT_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_pn_i2s_sched.sv
// Directed bench for pn_i2s_sched driven by a 2048-cycle LR frame model.
module tb_pn_i2s_sched;
    import pn_i2s_pkg::*;

    logic        ax_clk;
    logic        ax_rst;
    logic [31:0] s0_data;
    logic        s0_valid;
    logic        s0_ready;
    logic [31:0] s1_data;
    logic        s1_valid;
    logic        s1_ready;
    logic [1:0]  cfg_mode;
    logic        cfg_mute;
    logic        cfg_uz;
    logic        i2s_ready;
    logic        i2s_lrck;
    logic [31:0] i2s_data;
    logic        i2s_valid;
    logic [15:0] underrun_cnt;
    logic [15:0] frame_cnt;
    logic [1:0]  fsm_state;

    pn_i2s_sched #(.SYNC_STAGES(2), .CNT_W(16)) dut (
        .ax_clk       (ax_clk),
        .ax_rst       (ax_rst),
        .s0_data      (s0_data),
        .s0_valid     (s0_valid),
        .s0_ready     (s0_ready),
        .s1_data      (s1_data),
        .s1_valid     (s1_valid),
        .s1_ready     (s1_ready),
        .cfg_mode     (cfg_mode),
        .cfg_mute     (cfg_mute),
        .cfg_uz       (cfg_uz),
        .i2s_ready    (i2s_ready),
        .i2s_lrck     (i2s_lrck),
        .i2s_data     (i2s_data),
        .i2s_valid    (i2s_valid),
        .underrun_cnt (underrun_cnt),
        .frame_cnt    (frame_cnt),
        .fsm_state    (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        ax_clk = 1'b0;
        forever #5 ax_clk = ~ax_clk;
    end

    // ---------------- I2S TX model: lrck low = first 1024, ready high 32 per half
    int phase;
    initial begin
        phase     = 0;
        i2s_lrck  = 1'b0;
        i2s_ready = 1'b1;
        forever begin
            @(negedge ax_clk);
            phase     = (phase == 2047) ? 0 : phase + 1;
            i2s_lrck  = (phase >= 1024);
            i2s_ready = ((phase % 1024) < 32);
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          frames_seen = 0;
    int          unstable = 0;
    longint      cyc = 0;
    longint      last_pulse = 0;
    bit          have_last = 1'b0;
    bit          period_chk = 1'b1;
    logic [31:0] prev_data = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge ax_clk);
            cyc++;
            if (!ax_rst) begin
                if (i2s_valid) begin
                    frames_seen++;
                    obs_q.push_back(i2s_data);
                    if (period_chk && have_last) begin
                        check_eq("lr_period", 32'(cyc - last_pulse), 32'd2048);
                    end
                    last_pulse = cyc;
                    have_last  = 1'b1;
                end else if (i2s_data !== prev_data) begin
                    unstable++;
                end
            end
            prev_data = i2s_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push0(input logic [31:0] d);
        int k = 0;
        @(negedge ax_clk);
        s0_data  = d;
        s0_valid = 1'b1;
        while (!s0_ready && k < 6000) begin
            @(negedge ax_clk);
            k++;
        end
        check_eq("push0_accept", 32'(s0_ready), 32'd1);
        @(negedge ax_clk);
        s0_valid = 1'b0;
    endtask

    task automatic push1(input logic [31:0] d);
        int k = 0;
        @(negedge ax_clk);
        s1_data  = d;
        s1_valid = 1'b1;
        while (!s1_ready && k < 6000) begin
            @(negedge ax_clk);
            k++;
        end
        check_eq("push1_accept", 32'(s1_ready), 32'd1);
        @(negedge ax_clk);
        s1_valid = 1'b0;
    endtask

    task automatic wait_to(input int target);
        int k = 0;
        int budget;
        budget = (target - frames_seen) * 2048 + 4096;
        while (frames_seen < target && k < budget) begin
            @(negedge ax_clk);
            k++;
        end
        check_eq("frame_wait", 32'(frames_seen), 32'(target));
    endtask

    task automatic verify_frames(input string tag);
        check_eq({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            check_eq({tag, "_data"}, obs_q.pop_front(), exp_q.pop_front());
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    int base;
    initial begin
        ax_rst   = 1'b1;
        s0_data  = 32'd0;
        s0_valid = 1'b0;
        s1_data  = 32'd0;
        s1_valid = 1'b0;
        cfg_mode = MODE_S0;
        cfg_mute = 1'b0;
        cfg_uz   = 1'b1;

        // reset state, released in a quiet part of the left half
        repeat (4) @(negedge ax_clk);
        check_eq("rst_s0_ready", 32'(s0_ready), 32'd1);
        check_eq("rst_s1_ready", 32'(s1_ready), 32'd1);
        check_eq("rst_data", i2s_data, 32'd0);
        check_eq("rst_valid", 32'(i2s_valid), 32'd0);
        check_eq("rst_underrun", 32'(underrun_cnt), 32'd0);
        check_eq("rst_frames", 32'(frame_cnt), 32'd0);
        check_eq("rst_state", 32'(fsm_state), 32'(ST_WAIT_LOW));
        while (phase != 100) @(negedge ax_clk);
        ax_rst = 1'b0;

        // idle: three underrun frames of zero
        wait_to(frames_seen + 3);
        repeat (3) exp_q.push_back(32'd0);
        verify_frames("idle");
        check_eq("idle_frames", 32'(frame_cnt), 32'd3);
        check_eq("idle_underrun", 32'(underrun_cnt), 32'd3);
        @(negedge ax_clk);
        check_eq("valid_one_cycle", 32'(i2s_valid), 32'd0);

        // mode0 stream
        base = frames_seen;
        push0(32'h1111_2222);
        push0(32'h3333_4444);
        wait_to(base + 2);
        exp_q.push_back(32'h1111_2222);
        exp_q.push_back(32'h3333_4444);
        verify_frames("m0_stream");
        check_eq("m0_frames", 32'(frame_cnt), 32'd5);
        check_eq("m0_underrun", 32'(underrun_cnt), 32'd3);

        // mode3 saturating mix
        cfg_mode = MODE_MIX;
        base = frames_seen;
        push0(32'h7000_8001);
        push1(32'h2000_FFFE);
        wait_to(base + 1);
        exp_q.push_back(32'h7FFF_8000);
        verify_frames("mix");
        check_eq("mix_s0_free", 32'(s0_ready), 32'd1);
        check_eq("mix_s1_free", 32'(s1_ready), 32'd1);

        // mode2: s1 alone, then both held with s0 winning
        cfg_mode = MODE_PRI;
        base = frames_seen;
        push1(32'h0000_0005);
        wait_to(base + 1);
        exp_q.push_back(32'h0000_0005);
        verify_frames("pri_s1");
        check_eq("pri_s0_untouched", 32'(s0_ready), 32'd1);
        check_eq("pri_s1_free", 32'(s1_ready), 32'd1);
        base = frames_seen;
        push0(32'hAAAA_BBBB);
        push1(32'h0000_0009);
        wait_to(base + 1);
        exp_q.push_back(32'hAAAA_BBBB);
        verify_frames("pri_both");
        check_eq("pri_s1_kept", 32'(s1_ready), 32'd0);
        check_eq("pri_s0_free", 32'(s0_ready), 32'd1);
        wait_to(base + 2);
        exp_q.push_back(32'h0000_0009);
        verify_frames("pri_s1_late");
        check_eq("pri_s1_free2", 32'(s1_ready), 32'd1);
        check_eq("pri_frames", 32'(frame_cnt), 32'd9);

        // mute still consumes, no underrun
        cfg_mode = MODE_S1;
        cfg_mute = 1'b1;
        base = frames_seen;
        push1(32'h1111_1111);
        wait_to(base + 1);
        exp_q.push_back(32'd0);
        verify_frames("mute");
        check_eq("mute_s1_free", 32'(s1_ready), 32'd1);
        check_eq("mute_underrun", 32'(underrun_cnt), 32'd3);
        cfg_mute = 1'b0;

        // starvation with repeat, then with zero
        cfg_mode = MODE_S0;
        cfg_uz   = 1'b0;
        base = frames_seen;
        push0(32'h1234_5678);
        wait_to(base + 4);
        repeat (4) exp_q.push_back(32'h1234_5678);
        verify_frames("starve_rep");
        check_eq("starve_rep_underrun", 32'(underrun_cnt), 32'd6);
        cfg_uz = 1'b1;
        wait_to(frames_seen + 1);
        exp_q.push_back(32'd0);
        verify_frames("starve_zero");
        check_eq("starve_zero_underrun", 32'(underrun_cnt), 32'd7);
        check_eq("starve_frames", 32'(frame_cnt), 32'd15);

        // reset while ARMED with h0 full
        base = frames_seen;
        push0(32'hCAFE_F00D);
        wait_to(base + 1);
        exp_q.push_back(32'hCAFE_F00D);
        verify_frames("pre_rst");
        period_chk = 1'b0;
        push0(32'hDEAD_BEEF);
        begin
            int k = 0;
            while (fsm_state != ST_ARMED && k < 4096) begin
                @(negedge ax_clk);
                k++;
            end
        end
        check_eq("armed_reached", 32'(fsm_state), 32'(ST_ARMED));
        check_eq("armed_h0_full", 32'(s0_ready), 32'd0);
        ax_rst = 1'b1;
        @(negedge ax_clk);
        check_eq("mid_rst_s0_ready", 32'(s0_ready), 32'd1);
        check_eq("mid_rst_state", 32'(fsm_state), 32'(ST_WAIT_LOW));
        check_eq("mid_rst_data", i2s_data, 32'd0);
        check_eq("mid_rst_valid", 32'(i2s_valid), 32'd0);
        check_eq("mid_rst_frames", 32'(frame_cnt), 32'd0);
        check_eq("mid_rst_underrun", 32'(underrun_cnt), 32'd0);
        ax_rst = 1'b0;
        base = frames_seen;
        wait_to(base + 1);
        exp_q.push_back(32'd0);
        verify_frames("post_rst");
        check_eq("post_rst_underrun", 32'(underrun_cnt), 32'd1);
        check_eq("post_rst_frames", 32'(frame_cnt), 32'd1);

        check_eq("frame_stable", 32'(unstable), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
